// File: rtl/keypad_scanner_if.sv
// Keypad scanner signal bundle: keypad matrix lines plus the decoded key events
// handed to the downstream entry logic.
interface keypad_scanner_if #(
    parameter int ROWS = 4,
    parameter int COLS = 4
);
    localparam int KW = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1;

    logic [ROWS-1:0] row;
    logic [COLS-1:0] col;
    logic [KW-1:0]   key_code;
    logic            key_valid;
    logic            key_held;
    logic            key_release;
    logic            multi_err;

    // Scanner side: samples rows, drives columns and the key events.
    modport master (
        input  row,
        output col, key_code, key_valid, key_held, key_release, multi_err
    );

    // Keypad/consumer side.
    modport slave (
        output row,
        input  col, key_code, key_valid, key_held, key_release, multi_err
    );
endinterface

// File: rtl/keypad_scanner.sv
// R x C matrix keypad scanner: synchronises the row lines, walks the columns
// with a fixed dwell, debounces press and release, and rejects samples where
// more than one row is active in a column.
module keypad_scanner #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int DEBOUNCE   = 4,
    parameter int ACTIVE_LOW = 1
) (
    input  logic              clk,
    input  logic              rst,
    keypad_scanner_if.master  kp
);
    localparam int KW = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int TW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEBOUNCE + 1);

    localparam logic [ROWS-1:0] ROW_INACTIVE   = (ACTIVE_LOW != 0) ? {ROWS{1'b1}} : {ROWS{1'b0}};
    localparam logic [ROWS-1:0] ROW_POLARITY   = (ACTIVE_LOW != 0) ? {ROWS{1'b1}} : {ROWS{1'b0}};
    localparam logic [COLS-1:0] COL_POLARITY   = (ACTIVE_LOW != 0) ? {COLS{1'b1}} : {COLS{1'b0}};
    localparam logic [COLS-1:0] COL_ALL_ACTIVE = ~COL_POLARITY;
    localparam logic [ROWS-1:0] ROW_ONE        = ROWS'(1);
    localparam logic [COLS-1:0] COL_ONE        = COLS'(1);
    localparam logic [TW-1:0]   TIMER_LAST     = TW'(SCAN_DIV - 1);
    localparam logic [DW-1:0]   DEB_N          = DW'(DEBOUNCE);
    localparam logic [CW-1:0]   COL_LAST       = CW'(COLS - 1);
    localparam logic [KW-1:0]   COLS_K         = KW'(COLS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DEBOUNCE,
        ST_PRESSED
    } state_t;

    state_t          state_reg, state_next;
    logic [ROWS-1:0] row_meta_reg, row_sync_reg;
    logic [TW-1:0]   timer_reg, timer_next;
    logic [CW-1:0]   col_idx_reg, col_idx_next;
    logic [RW-1:0]   row_idx_reg, row_idx_next;
    logic [DW-1:0]   cnt_reg, cnt_next;
    logic [DW-1:0]   rel_cnt_reg, rel_cnt_next;
    logic [COLS-1:0] col_reg, col_next;
    logic [KW-1:0]   key_code_reg, key_code_next;
    logic            key_valid_reg, key_valid_next;
    logic            key_held_reg, key_held_next;
    logic            key_release_reg, key_release_next;
    logic            multi_err_reg, multi_err_next;

    logic [ROWS-1:0] sample;
    logic            dwell_end;
    logic            row_any;
    logic            row_one;
    logic            row_multi;
    logic [RW-1:0]   hit_idx;
    logic [ROWS-1:0] captured_row;
    logic [KW-1:0]   captured_code;

    // Two-flop synchroniser for the asynchronous row lines, parked at the
    // inactive level so reset never looks like a pressed key.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta_reg <= ROW_INACTIVE;
            row_sync_reg <= ROW_INACTIVE;
        end else begin
            row_meta_reg <= kp.row;
            row_sync_reg <= row_meta_reg;
        end
    end

    // Active-high view of the synchronised rows, plus one-hot classification.
    assign sample        = row_sync_reg ^ ROW_POLARITY;
    assign dwell_end     = (timer_reg == TIMER_LAST);
    assign row_any       = |sample;
    assign row_one       = $onehot(sample);
    assign row_multi     = row_any && !row_one;
    assign captured_row  = ROW_ONE << row_idx_reg;
    assign captured_code = KW'(row_idx_reg) * COLS_K + KW'(col_idx_reg);

    // Index of the active row; only meaningful when exactly one row is active.
    always_comb begin
        hit_idx = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (sample[i]) begin
                hit_idx = RW'(i);
            end
        end
    end

    // Next-state, counters and registered-output next values.
    always_comb begin
        state_next       = state_reg;
        col_idx_next     = col_idx_reg;
        row_idx_next     = row_idx_reg;
        cnt_next         = cnt_reg;
        rel_cnt_next     = rel_cnt_reg;
        key_code_next    = key_code_reg;
        key_held_next    = key_held_reg;
        key_valid_next   = 1'b0;
        key_release_next = 1'b0;
        multi_err_next   = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (dwell_end && row_any) begin
                    state_next   = ST_SCAN;
                    col_idx_next = '0;
                end
            end

            ST_SCAN: begin
                if (dwell_end) begin
                    if (row_one) begin
                        row_idx_next = hit_idx;
                        cnt_next     = DW'(1);
                        state_next   = ST_DEBOUNCE;
                    end else begin
                        // Ghosting / several keys in one column: flag and move on.
                        multi_err_next = row_multi;
                        if (col_idx_reg == COL_LAST) begin
                            state_next   = ST_IDLE;
                            col_idx_next = '0;
                        end else begin
                            col_idx_next = col_idx_reg + CW'(1);
                        end
                    end
                end
            end

            ST_DEBOUNCE: begin
                // The count already satisfied on entry only happens with a
                // single-sample debounce; accept without waiting for a dwell.
                if (cnt_reg == DEB_N) begin
                    state_next     = ST_PRESSED;
                    key_code_next  = captured_code;
                    key_held_next  = 1'b1;
                    key_valid_next = 1'b1;
                    cnt_next       = '0;
                    rel_cnt_next   = '0;
                end else if (dwell_end) begin
                    if (sample == captured_row) begin
                        if (cnt_reg + DW'(1) == DEB_N) begin
                            state_next     = ST_PRESSED;
                            key_code_next  = captured_code;
                            key_held_next  = 1'b1;
                            key_valid_next = 1'b1;
                            cnt_next       = '0;
                            rel_cnt_next   = '0;
                        end else begin
                            cnt_next = cnt_reg + DW'(1);
                        end
                    end else begin
                        // Bounce: abandon silently.
                        state_next   = ST_IDLE;
                        cnt_next     = '0;
                        col_idx_next = '0;
                    end
                end
            end

            ST_PRESSED: begin
                // Only the captured row matters; other keys are ignored while held.
                if (dwell_end) begin
                    if (!sample[row_idx_reg]) begin
                        if (rel_cnt_reg + DW'(1) == DEB_N) begin
                            state_next       = ST_IDLE;
                            key_held_next    = 1'b0;
                            key_release_next = 1'b1;
                            rel_cnt_next     = '0;
                            col_idx_next     = '0;
                        end else begin
                            rel_cnt_next = rel_cnt_reg + DW'(1);
                        end
                    end else begin
                        rel_cnt_next = '0;
                    end
                end
            end

            default: begin
                state_next   = ST_IDLE;
                col_idx_next = '0;
                cnt_next     = '0;
                rel_cnt_next = '0;
            end
        endcase

        // Dwell restarts on any state or column change so each column gets a
        // full settling window before it is sampled.
        if ((state_next != state_reg) || (col_idx_next != col_idx_reg) || dwell_end) begin
            timer_next = '0;
        end else begin
            timer_next = timer_reg + TW'(1);
        end

        if (state_next == ST_IDLE) begin
            col_next = COL_ALL_ACTIVE;
        end else begin
            col_next = (COL_ONE << col_idx_next) ^ COL_POLARITY;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            timer_reg       <= '0;
            col_idx_reg     <= '0;
            row_idx_reg     <= '0;
            cnt_reg         <= '0;
            rel_cnt_reg     <= '0;
            col_reg         <= COL_ALL_ACTIVE;
            key_code_reg    <= '0;
            key_valid_reg   <= 1'b0;
            key_held_reg    <= 1'b0;
            key_release_reg <= 1'b0;
            multi_err_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            timer_reg       <= timer_next;
            col_idx_reg     <= col_idx_next;
            row_idx_reg     <= row_idx_next;
            cnt_reg         <= cnt_next;
            rel_cnt_reg     <= rel_cnt_next;
            col_reg         <= col_next;
            key_code_reg    <= key_code_next;
            key_valid_reg   <= key_valid_next;
            key_held_reg    <= key_held_next;
            key_release_reg <= key_release_next;
            multi_err_reg   <= multi_err_next;
        end
    end

    assign kp.col         = col_reg;
    assign kp.key_code    = key_code_reg;
    assign kp.key_valid   = key_valid_reg;
    assign kp.key_held    = key_held_reg;
    assign kp.key_release = key_release_reg;
    assign kp.multi_err   = multi_err_reg;
endmodule

// File: tb/tb_keypad_scanner.sv
// Testbench for keypad_scanner: a 4x4 active-low instance and a 2x3
// active-high instance, each fed by a behavioural key-matrix model. Expected
// key events are queued when stimulus is applied and popped as strobes appear.
module tb_keypad_scanner;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    typedef enum int { EV_VALID, EV_RELEASE, EV_MULTI } ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        logic [3:0] code;
    } ev_t;

    ev_t q1[$];
    ev_t q2[$];

    keypad_scanner_if #(.ROWS(4), .COLS(4)) kp1();
    keypad_scanner_if #(.ROWS(2), .COLS(3)) kp2();

    keypad_scanner #(.ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(3), .ACTIVE_LOW(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .kp  (kp1)
    );

    keypad_scanner #(.ROWS(2), .COLS(3), .SCAN_DIV(4), .DEBOUNCE(2), .ACTIVE_LOW(0)) dut2 (
        .clk (clk),
        .rst (rst),
        .kp  (kp2)
    );

    // Key matrices: bit r*COLS+c set means the switch at row r / column c is closed.
    logic [15:0] keys1 = '0;
    logic [5:0]  keys2 = '0;
    logic [3:0]  row1_act;
    logic [1:0]  row2_act;

    // A closed switch connects its row to its column when the column is driven active.
    always_comb begin
        row1_act = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys1[r*4+c] && !kp1.col[c]) row1_act[r] = 1'b1;
    end
    always_comb begin
        row2_act = '0;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 3; c++)
                if (keys2[r*3+c] && kp2.col[c]) row2_act[r] = 1'b1;
    end
    assign kp1.row = ~row1_act;
    assign kp2.row = row2_act;

    // Scoreboard for the 4x4 instance.
    always @(negedge clk) begin : mon1
        ev_t obs;
        ev_t exp_ev;
        int  n_str;
        if (!rst && (kp1.key_valid || kp1.key_release || kp1.multi_err)) begin
            n_str = int'(kp1.key_valid) + int'(kp1.key_release) + int'(kp1.multi_err);
            obs.kind = kp1.key_valid ? EV_VALID : (kp1.key_release ? EV_RELEASE : EV_MULTI);
            obs.code = kp1.key_code;
            total++;
            if (q1.size() == 0) begin
                bad++;
                $display("FAIL dut1_event: got kind=%0d code=%0d strobes=%0d, expected no event", obs.kind, obs.code, n_str);
            end else begin
                exp_ev = q1.pop_front();
                if (n_str != 1 || obs.kind != exp_ev.kind ||
                    (exp_ev.kind != EV_MULTI && obs.code !== exp_ev.code)) begin
                    bad++;
                    $display("FAIL dut1_event: got kind=%0d code=%0d strobes=%0d, expected kind=%0d code=%0d strobes=1",
                             obs.kind, obs.code, n_str, exp_ev.kind, exp_ev.code);
                end
            end
        end
    end

    // Scoreboard for the 2x3 instance.
    always @(negedge clk) begin : mon2
        ev_t obs;
        ev_t exp_ev;
        int  n_str;
        if (!rst && (kp2.key_valid || kp2.key_release || kp2.multi_err)) begin
            n_str = int'(kp2.key_valid) + int'(kp2.key_release) + int'(kp2.multi_err);
            obs.kind = kp2.key_valid ? EV_VALID : (kp2.key_release ? EV_RELEASE : EV_MULTI);
            obs.code = 4'(kp2.key_code);
            total++;
            if (q2.size() == 0) begin
                bad++;
                $display("FAIL dut2_event: got kind=%0d code=%0d strobes=%0d, expected no event", obs.kind, obs.code, n_str);
            end else begin
                exp_ev = q2.pop_front();
                if (n_str != 1 || obs.kind != exp_ev.kind ||
                    (exp_ev.kind != EV_MULTI && obs.code !== exp_ev.code)) begin
                    bad++;
                    $display("FAIL dut2_event: got kind=%0d code=%0d strobes=%0d, expected kind=%0d code=%0d strobes=1",
                             obs.kind, obs.code, n_str, exp_ev.kind, exp_ev.code);
                end
            end
        end
    end

    // Waits until the given queue drains or the cycle budget runs out; returns cycles used.
    task automatic wait_q1(input int budget, output int used);
        used = 0;
        while (q1.size() != 0 && used < budget) begin
            @(posedge clk); #2;
            used++;
        end
    endtask

    task automatic wait_q2(input int budget, output int used);
        used = 0;
        while (q2.size() != 0 && used < budget) begin
            @(posedge clk); #2;
            used++;
        end
    endtask

    task automatic test_reset();
        #3 rst = 1'b1;
        #1;
        total++; if (kp1.col !== 4'b0000) begin bad++; $display("FAIL reset_col1: got %b, expected 0000", kp1.col); end
        total++; if (kp1.key_code !== 4'd0) begin bad++; $display("FAIL reset_code1: got %0d, expected 0", kp1.key_code); end
        total++; if ({kp1.key_valid, kp1.key_held, kp1.key_release, kp1.multi_err} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags1: got %b, expected 0000", {kp1.key_valid, kp1.key_held, kp1.key_release, kp1.multi_err});
        end
        total++; if (kp2.col !== 3'b111) begin bad++; $display("FAIL reset_col2: got %b, expected 111", kp2.col); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_clean_press();
        int used;
        keys1 = '0;
        keys1[2*4+1] = 1'b1;
        q1.push_back('{kind: EV_VALID, code: 4'd9});
        wait_q1(200, used);
        total++; if (q1.size() != 0) begin bad++; $display("FAIL press_timeout: pending=%0d, expected 0", q1.size()); q1.delete(); end
        total++; if (kp1.key_held !== 1'b1) begin bad++; $display("FAIL press_held: got %b, expected 1", kp1.key_held); end
        total++; if (kp1.col !== 4'b1101) begin bad++; $display("FAIL press_col: got %b, expected 1101", kp1.col); end
        total++; if (kp1.key_code !== 4'd9) begin bad++; $display("FAIL press_code: got %0d, expected 9", kp1.key_code); end
        repeat (40) @(negedge clk);
        total++; if (kp1.key_held !== 1'b1 || kp1.col !== 4'b1101) begin
            bad++; $display("FAIL press_hold: got held=%b col=%b, expected held=1 col=1101", kp1.key_held, kp1.col);
        end
    endtask

    task automatic test_release();
        int used;
        @(posedge clk); #2;
        q1.push_back('{kind: EV_RELEASE, code: 4'd9});
        keys1 = '0;
        wait_q1(100, used);
        total++; if (q1.size() != 0) begin bad++; $display("FAIL release_timeout: pending=%0d, expected 0", q1.size()); q1.delete(); end
        total++; if (used < 11 || used > 16) begin bad++; $display("FAIL release_latency: got %0d cycles, expected 11..16", used); end
        #3;
        total++; if (kp1.key_held !== 1'b0) begin bad++; $display("FAIL release_held: got %b, expected 0", kp1.key_held); end
        total++; if (kp1.col !== 4'b0000) begin bad++; $display("FAIL release_col: got %b, expected 0000", kp1.col); end
        total++; if (kp1.key_code !== 4'd9) begin bad++; $display("FAIL release_code: got %0d, expected 9", kp1.key_code); end
    endtask

    task automatic test_bounce();
        int i;
        keys1 = '0;
        keys1[2*4+1] = 1'b1;
        i = 0;
        while (kp1.col !== 4'b1101 && i < 100) begin
            @(negedge clk);
            i++;
        end
        total++; if (kp1.col !== 4'b1101) begin bad++; $display("FAIL bounce_scan: got col=%b, expected 1101", kp1.col); end
        repeat (4) @(posedge clk);
        #2 keys1 = '0;
        repeat (30) @(negedge clk);
        total++; if (kp1.col !== 4'b0000) begin bad++; $display("FAIL bounce_col: got %b, expected 0000", kp1.col); end
        total++; if (kp1.key_held !== 1'b0) begin bad++; $display("FAIL bounce_held: got %b, expected 0", kp1.key_held); end
    endtask

    task automatic test_multi();
        int used;
        keys1 = '0;
        keys1[0*4+3] = 1'b1;
        keys1[3*4+3] = 1'b1;
        q1.push_back('{kind: EV_MULTI, code: 4'd0});
        q1.push_back('{kind: EV_MULTI, code: 4'd0});
        wait_q1(200, used);
        keys1 = '0;
        total++; if (q1.size() != 0) begin bad++; $display("FAIL multi_timeout: pending=%0d, expected 0", q1.size()); q1.delete(); end
        repeat (40) @(negedge clk);
        total++; if (kp1.col !== 4'b0000) begin bad++; $display("FAIL multi_col: got %b, expected 0000", kp1.col); end
        total++; if (kp1.key_held !== 1'b0) begin bad++; $display("FAIL multi_held: got %b, expected 0", kp1.key_held); end
    endtask

    task automatic test_param();
        int used;
        keys2 = '0;
        keys2[1*3+2] = 1'b1;
        q2.push_back('{kind: EV_VALID, code: 4'd5});
        wait_q2(200, used);
        total++; if (q2.size() != 0) begin bad++; $display("FAIL param_timeout: pending=%0d, expected 0", q2.size()); q2.delete(); end
        total++; if (kp2.key_code !== 3'd5) begin bad++; $display("FAIL param_code: got %0d, expected 5", kp2.key_code); end
        total++; if (kp2.col !== 3'b100) begin bad++; $display("FAIL param_col: got %b, expected 100", kp2.col); end
        total++; if (kp2.key_held !== 1'b1) begin bad++; $display("FAIL param_held: got %b, expected 1", kp2.key_held); end
        q2.push_back('{kind: EV_RELEASE, code: 4'd5});
        keys2 = '0;
        wait_q2(100, used);
        total++; if (q2.size() != 0) begin bad++; $display("FAIL param_rel_timeout: pending=%0d, expected 0", q2.size()); q2.delete(); end
        #3;
        total++; if (kp2.key_held !== 1'b0 || kp2.col !== 3'b111) begin
            bad++; $display("FAIL param_release: got held=%b col=%b, expected held=0 col=111", kp2.key_held, kp2.col);
        end
    endtask

    task automatic test_reset_mid();
        int used;
        keys1 = '0;
        keys1[2*4+1] = 1'b1;
        q1.push_back('{kind: EV_VALID, code: 4'd9});
        wait_q1(200, used);
        total++; if (q1.size() != 0) begin bad++; $display("FAIL mid_timeout: pending=%0d, expected 0", q1.size()); q1.delete(); end
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        total++; if (kp1.col !== 4'b0000) begin bad++; $display("FAIL mid_col: got %b, expected 0000", kp1.col); end
        total++; if (kp1.key_held !== 1'b0) begin bad++; $display("FAIL mid_held: got %b, expected 0", kp1.key_held); end
        total++; if (kp1.key_code !== 4'd0) begin bad++; $display("FAIL mid_code: got %0d, expected 0", kp1.key_code); end
        keys1 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        total++; if (kp1.col !== 4'b0000 || kp1.key_held !== 1'b0) begin
            bad++; $display("FAIL mid_after: got col=%b held=%b, expected col=0000 held=0", kp1.col, kp1.key_held);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_release();
        test_bounce();
        test_multi();
        test_param();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
